// File: rtl/imem_pkg.sv
// imem_pkg -- shared constants, helpers and types for the clocked
// instruction memory (imem_fetch) and its response buffer (imem_rsp_buf).
//
// Contents:
//   DEF_DATA_W / DEF_DEPTH / DEF_ADDR_W : default geometry of imem_fetch
//   byte_off_w(data_w) : number of byte-offset bits inside one word
//   idx_w(depth)       : number of word-index bits
//   imem_rsp_t         : response record {data, addr, fault} in the default
//                        geometry (imem_fetch builds the same layout from its
//                        own parameters so non-default widths also work)
package imem_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_DEPTH  = 1024;
  localparam int unsigned DEF_ADDR_W = 32;

  function automatic int unsigned byte_off_w(input int unsigned data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int unsigned idx_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  typedef struct packed {
    logic [DEF_DATA_W-1:0] data;
    logic [DEF_ADDR_W-1:0] addr;
    logic                  fault;
  } imem_rsp_t;

endpackage

// File: rtl/imem_rsp_buf.sv
// imem_rsp_buf -- two-entry FIFO holding fetch responses.
//
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   flush       : empties the FIFO on the edge (same effect as rst)
//   push        : write push_data at the tail
//   push_data   : entry to store (type T)
//   pop         : drop the head entry
//   head        : current head entry (undefined when count == 0)
//   count       : number of occupied entries, 0..2
//
// The owner never pushes into a full FIFO and never pops an empty one;
// imem_fetch's ready logic guarantees both.
module imem_rsp_buf
  import imem_pkg::*;
#(
  parameter type T = imem_rsp_t
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  T           push_data,
  input  logic       pop,
  output T           head,
  output logic [1:0] count
);

  T           ent_q [2];
  logic       rd_ptr_q;
  logic       wr_ptr_q;
  logic [1:0] count_q;

  // Entry storage carries no reset: validity lives entirely in count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head  = ent_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/imem_fetch.sv
// imem_fetch -- clocked instruction memory with a valid/ready fetch port.
//
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   req_valid/req_ready/req_addr : fetch request (byte address)
//   rsp_valid/rsp_ready          : response handshake
//   rsp_data/rsp_addr/rsp_fault  : response payload (zero when !rsp_valid)
//   flush                        : drop everything in flight, block accept
//   wr_en/wr_addr/wr_data        : program-load write, read-first vs fetch
//
// Build option: define IMEM_FAULT_EN to flag misaligned / out-of-range
// fetches (rsp_fault=1, rsp_data=0) and to drop such writes. Without it the
// address simply wraps modulo DEPTH words and rsp_fault is always 0.
//
// Pipeline: an accepted request is read into a one-entry read stage; the
// response seen on rsp_* is the oldest of {buffer, read stage}. A read stage
// entry that is not consumed in its first cycle moves into the 2-entry
// buffer, so buffer + read stage never exceeds two responses.
module imem_fetch
  import imem_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic              rsp_fault,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  localparam int unsigned OFF_W = byte_off_w(DATA_W);
  localparam int unsigned IDX_W = idx_w(DEPTH);
  localparam int unsigned HI_SH = OFF_W + IDX_W;
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);

`ifdef IMEM_FAULT_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              fault;
  } rsp_t;

  // Misaligned (byte offset set) or beyond the array (any bit above the index).
  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return ((a & OFF_MASK) != '0) || ((a >> HI_SH) != '0);
  endfunction

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic              rs_valid_q;
  logic [ADDR_W-1:0] rs_addr_q;
  logic              rs_fault_q;

  logic [IDX_W-1:0]  req_idx;
  logic [IDX_W-1:0]  wr_idx;
  logic              req_fault;
  logic              wr_ok;
  logic              accept;
  logic [1:0]        buf_count;
  logic [1:0]        occ;
  logic              buf_empty;
  logic              pop;
  logic              buf_pop;
  logic              buf_push;
  rsp_t              rs_entry;
  rsp_t              buf_head;
  rsp_t              head;

  assign req_idx   = req_addr[OFF_W +: IDX_W];
  assign wr_idx    = wr_addr[OFF_W +: IDX_W];
  assign req_fault = FAULT_EN && addr_bad(req_addr);
  assign wr_ok     = !(FAULT_EN && addr_bad(wr_addr));

  // Ready only when the new request is guaranteed a slot behind everything
  // already in flight.
  assign occ       = buf_count + {1'b0, rs_valid_q};
  assign req_ready = !rst && !flush && (occ < 2'd2);
  assign accept    = req_valid && req_ready;

  // Array and its registered read port; non-blocking update gives
  // read-first behaviour on a same-cycle write to the fetched word.
  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      mem_q[wr_idx] <= wr_data;
    end
    if (accept) begin
      rd_data_q <= mem_q[req_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rs_valid_q <= 1'b0;
      rs_addr_q  <= '0;
      rs_fault_q <= 1'b0;
    end else begin
      rs_valid_q <= accept;
      if (accept) begin
        rs_addr_q  <= req_addr;
        rs_fault_q <= req_fault;
      end
    end
  end

  always_comb begin
    rs_entry       = '0;
    rs_entry.data  = rs_fault_q ? '0 : rd_data_q;
    rs_entry.addr  = rs_addr_q;
    rs_entry.fault = rs_fault_q;
  end

  assign buf_empty = (buf_count == 2'd0);
  assign rsp_valid = !buf_empty || rs_valid_q;
  assign head      = buf_empty ? rs_entry : buf_head;
  assign pop       = rsp_valid && rsp_ready;
  assign buf_pop   = pop && !buf_empty;
  // The read stage is always vacated: consumed directly or parked in the buffer.
  assign buf_push  = rs_valid_q && !(pop && buf_empty);

  imem_rsp_buf #(
    .T (rsp_t)
  ) u_rsp_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (buf_push),
    .push_data (rs_entry),
    .pop       (buf_pop),
    .head      (buf_head),
    .count     (buf_count)
  );

  // Payload forced to zero when idle so reset/flush leave clean outputs.
  assign rsp_data  = rsp_valid ? head.data  : '0;
  assign rsp_addr  = rsp_valid ? head.addr  : '0;
  assign rsp_fault = rsp_valid ? head.fault : 1'b0;

endmodule
